fb_scanout_reader: RTL

//  Read side of the framebuffer: streams a finished frame out of the framebuffer read port
//  in raster order (x fastest, then y) to the display/palette stage.

---
 rtl/fb_scanout_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: issues raster-order reads under a credit limit, buffers the returning
// pixels in a show-ahead FIFO and streams them out with end-of-line/end-of-frame markers.
module fb_scanout_reader #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 480,
   parameter int ADDR_W     = 19,
   parameter int PIX_W      = 4,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              frame_done,
   output logic              busy,
   output logic              err_underflow,
   output logic              err_overrun
);

   localparam int TOTAL = H_ACTIVE * V_ACTIVE;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
   localparam logic [XW-1:0]     X_LAST    = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0]     Y_LAST    = YW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_W-1:0]     addr_reg;
   logic [RD_LATENCY-1:0] valid_pipe_reg;
   logic [PIX_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]         count_reg;
   logic [XW-1:0]         x_reg;
   logic [YW-1:0]         y_reg;
   logic                  err_underflow_reg, err_overrun_reg;

   logic [CW-1:0]         outstanding;
   logic                  credit_ok, push, pop, start_ok;

   // Reads still in the latency pipeline count against the FIFO so it can never overflow.
   always_comb begin
      outstanding = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         outstanding = outstanding + CW'(valid_pipe_reg[i]);
   end

   assign credit_ok = ({1'b0, outstanding} + {1'b0, count_reg}) < (CW+1)'(FIFO_DEPTH);
   assign push      = valid_pipe_reg[RD_LATENCY-1];
   assign pix_valid = (count_reg != '0);
   assign pop       = pix_valid && pix_ready;
   assign pix_data  = pix_valid ? fifo_mem[rd_ptr_reg] : '0;
   assign pix_eol   = pix_valid && (x_reg == X_LAST);
   assign pix_eof   = pix_valid && (x_reg == X_LAST) && (y_reg == Y_LAST);
   assign rd_addr   = addr_reg;
   assign err_underflow = err_underflow_reg;
   assign err_overrun   = err_overrun_reg;
   assign start_ok  = (state_reg == IDLE) && frame_start;

   always_comb begin
      state_next = state_reg;
      rd_en      = 1'b0;
      frame_done = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (frame_start) state_next = FETCH;
         end
         FETCH: begin
            busy  = 1'b1;
            rd_en = credit_ok;
            if (credit_ok && addr_reg == LAST_ADDR) state_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (outstanding == '0 && count_reg == '0) begin
               frame_done = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= IDLE;
         addr_reg          <= '0;
         valid_pipe_reg    <= '0;
         wr_ptr_reg        <= '0;
         rd_ptr_reg        <= '0;
         count_reg         <= '0;
         x_reg             <= '0;
         y_reg             <= '0;
         err_underflow_reg <= 1'b0;
         err_overrun_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;

         for (int i = RD_LATENCY - 1; i > 0; i--)
            valid_pipe_reg[i] <= valid_pipe_reg[i-1];
         valid_pipe_reg[0] <= rd_en;

         // The address register parks on the last address once the frame is issued.
         if (start_ok)
            addr_reg <= '0;
         else if (rd_en && addr_reg != LAST_ADDR)
            addr_reg <= addr_reg + ADDR_W'(1);

         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (push && !pop)
            count_reg <= count_reg + CW'(1);
         else if (pop && !push)
            count_reg <= count_reg - CW'(1);

         if (start_ok) begin
            x_reg <= '0;
            y_reg <= '0;
         end else if (pop) begin
            if (x_reg == X_LAST) begin
               x_reg <= '0;
               y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
            end else begin
               x_reg <= x_reg + XW'(1);
            end
         end

         if (state_reg == FETCH && pix_ready && count_reg == '0)
            err_underflow_reg <= 1'b1;
         if (frame_start && busy)
            err_overrun_reg <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_reg] <= rd_data;
   end

endmodule
